// File: rtl/mem_io_responder.sv
// Byte-bus responder: RAM, UART TX/RX FIFOs, cycle counter and stop request; mem_din is one cycle behind the address.
// No stall on the bus: io_buffer_full warns one slot early, and a write to a full TX FIFO is dropped and flagged.
module mem_io_responder #(
  parameter int    ADDR_WIDTH = 17,
  parameter int    TX_DEPTH   = 8,
  parameter int    RX_DEPTH   = 4,
  parameter string INIT_FILE  = ""
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  output logic        rx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_byte,
  input  logic        tx_ready,
  output logic        tx_overflow,
  output logic        sim_done
);
  localparam int TXPW = $clog2(TX_DEPTH);
  localparam int RXPW = $clog2(RX_DEPTH);
  localparam int TXCW = TXPW + 1;
  localparam int RXCW = RXPW + 1;
  localparam logic [TXPW:0] TX_FULL = TXCW'(TX_DEPTH);
  localparam logic [TXPW:0] TX_NF   = TXCW'(TX_DEPTH - 1);
  localparam logic [RXPW:0] RX_FULL = RXCW'(RX_DEPTH);

  logic [7:0] ram_q [2**ADDR_WIDTH];
  logic [7:0] tx_mem_q [TX_DEPTH];
  logic [7:0] rx_mem_q [RX_DEPTH];

  logic [TXPW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [TXPW:0]   tx_cnt_q, tx_cnt_d;
  logic [RXPW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [RXPW:0]   rx_cnt_q, rx_cnt_d;
  logic [31:0]     cnt_q, cnt_d, snap_q, snap_d;
  logic [7:0]      mem_din_q, mem_din_d;
  logic            ibf_q, ibf_d, stop_req_q, stop_req_d;
  logic            tx_ovf_q, tx_ovf_d, sim_done_q, sim_done_d;
  logic            tx_push, tx_pop, tx_drop, rx_push, rx_pop;

  logic                  io_sel, ram_sel;
  logic [2:0]            off;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  unused_hi;

  assign io_sel    = (mem_a[17:16] == 2'b11);
  assign ram_sel   = !io_sel && (mem_a[17:ADDR_WIDTH] == '0);
  assign off       = mem_a[2:0];
  assign ram_addr  = mem_a[ADDR_WIDTH-1:0];
  assign unused_hi = ^mem_a[31:18];

  assign tx_valid = (tx_cnt_q != '0);
  assign tx_byte  = tx_mem_q[tx_rd_q];
  assign rx_ready = (rx_cnt_q != RX_FULL);

  always_comb begin
    tx_pop     = tx_valid && tx_ready;
    rx_push    = rx_valid && rx_ready;
    tx_push    = 1'b0;
    tx_drop    = 1'b0;
    rx_pop     = 1'b0;
    snap_d     = snap_q;
    stop_req_d = stop_req_q;
    mem_din_d  = mem_din_q;
    if (mem_wr) begin
      // A pop in this same cycle frees the slot the push needs.
      if (io_sel && off == 3'd0 && mem_dout != 8'h00) begin
        if (tx_cnt_q != TX_FULL || tx_pop) tx_push = 1'b1;
        else                               tx_drop = 1'b1;
      end
      if (io_sel && off == 3'd4) stop_req_d = 1'b1;
    end else if (ram_sel) begin
      mem_din_d = ram_q[ram_addr];
    end else if (io_sel) begin
      case (off)
        3'd0: begin
          mem_din_d = 8'h00;
          if (rx_cnt_q != '0) begin
            mem_din_d = rx_mem_q[rx_rd_q];
            rx_pop    = 1'b1;
          end
        end
        3'd4: begin
          mem_din_d = cnt_q[7:0];
          snap_d    = cnt_q;
        end
        3'd5:    mem_din_d = snap_q[15:8];
        3'd6:    mem_din_d = snap_q[23:16];
        3'd7:    mem_din_d = snap_q[31:24];
        default: mem_din_d = 8'h00;
      endcase
    end else begin
      mem_din_d = 8'h00;
    end

    tx_wr_d    = tx_wr_q + TXPW'(tx_push);
    tx_rd_d    = tx_rd_q + TXPW'(tx_pop);
    tx_cnt_d   = tx_cnt_q + TXCW'(tx_push) - TXCW'(tx_pop);
    rx_wr_d    = rx_wr_q + RXPW'(rx_push);
    rx_rd_d    = rx_rd_q + RXPW'(rx_pop);
    rx_cnt_d   = rx_cnt_q + RXCW'(rx_push) - RXCW'(rx_pop);
    cnt_d      = cnt_q + 32'd1;
    ibf_d      = (tx_cnt_d >= TX_NF);
    tx_ovf_d   = tx_ovf_q | tx_drop;
    sim_done_d = sim_done_q | (stop_req_q && tx_cnt_q == '0);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      tx_wr_q    <= '0;
      tx_rd_q    <= '0;
      tx_cnt_q   <= '0;
      rx_wr_q    <= '0;
      rx_rd_q    <= '0;
      rx_cnt_q   <= '0;
      cnt_q      <= '0;
      snap_q     <= '0;
      mem_din_q  <= '0;
      ibf_q      <= 1'b0;
      stop_req_q <= 1'b0;
      tx_ovf_q   <= 1'b0;
      sim_done_q <= 1'b0;
    end else begin
      tx_wr_q    <= tx_wr_d;
      tx_rd_q    <= tx_rd_d;
      tx_cnt_q   <= tx_cnt_d;
      rx_wr_q    <= rx_wr_d;
      rx_rd_q    <= rx_rd_d;
      rx_cnt_q   <= rx_cnt_d;
      cnt_q      <= cnt_d;
      snap_q     <= snap_d;
      mem_din_q  <= mem_din_d;
      ibf_q      <= ibf_d;
      stop_req_q <= stop_req_d;
      tx_ovf_q   <= tx_ovf_d;
      sim_done_q <= sim_done_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (tx_push) tx_mem_q[tx_wr_q] <= mem_dout;
    if (rx_push) rx_mem_q[rx_wr_q] <= rx_byte;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in && mem_wr && ram_sel) ram_q[ram_addr] <= mem_dout;
  end

  assign mem_din        = mem_din_q;
  assign io_buffer_full = ibf_q;
  assign tx_overflow    = tx_ovf_q;
  assign sim_done       = sim_done_q;
endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: vector table for RAM/hole decode, hand sequences for FIFOs, counter and stop.
module tb_mem_io_responder;
  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [31:0] mem_a = '0;
  logic [7:0]  mem_dout = '0;
  logic        mem_wr = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_byte = '0;
  logic        tx_ready = 1'b0;
  logic [7:0]  mem_din;
  logic        io_buffer_full, rx_ready, tx_valid, tx_overflow, sim_done;
  logic [7:0]  tx_byte;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] exp_cnt;

  mem_io_responder dut (
    .clk_in(clk_in), .rst_in(rst_in), .mem_a(mem_a), .mem_dout(mem_dout),
    .mem_wr(mem_wr), .mem_din(mem_din), .io_buffer_full(io_buffer_full),
    .rx_valid(rx_valid), .rx_byte(rx_byte), .rx_ready(rx_ready),
    .tx_valid(tx_valid), .tx_byte(tx_byte), .tx_ready(tx_ready),
    .tx_overflow(tx_overflow), .sim_done(sim_done)
  );

  always #5 clk_in = ~clk_in;

  // Reference cycle counter: cleared by reset, +1 per edge otherwise.
  always @(posedge clk_in) begin
    if (rst_in) exp_cnt <= 32'd0;
    else        exp_cnt <= exp_cnt + 32'd1;
  end

  typedef struct {
    logic        wr;
    logic [31:0] a;
    logic [7:0]  d;
    logic [7:0]  exp_din;
  } vec_t;
  vec_t vecs[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    @(negedge clk_in);
    mem_wr   = 1'b0;
    mem_a    = 32'h0;
    mem_dout = 8'h00;
  endtask

  task automatic acc(input logic wr, input logic [31:0] a, input logic [7:0] d);
    mem_wr   = wr;
    mem_a    = a;
    mem_dout = d;
    step();
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]  wbytes[10];
    logic [7:0]  b0, b1, b2, b3;
    logic [31:0] cap;
    int          accepted, g;

    vecs[0]  = '{1'b1, 32'h0000_0010, 8'hA5, 8'h00};
    vecs[1]  = '{1'b0, 32'h0000_0010, 8'h00, 8'hA5};
    vecs[2]  = '{1'b0, 32'h0002_0004, 8'h00, 8'h00};
    vecs[3]  = '{1'b1, 32'h0000_0011, 8'h5A, 8'h00};
    vecs[4]  = '{1'b0, 32'h0000_0011, 8'h00, 8'h5A};
    vecs[5]  = '{1'b1, 32'h0001_FFFF, 8'h3C, 8'h5A};
    vecs[6]  = '{1'b0, 32'h0001_FFFF, 8'h00, 8'h3C};
    vecs[7]  = '{1'b1, 32'h0002_0010, 8'h77, 8'h3C};
    vecs[8]  = '{1'b0, 32'h0000_0010, 8'h00, 8'hA5};
    vecs[9]  = '{1'b0, 32'h0002_0010, 8'h00, 8'h00};
    vecs[10] = '{1'b0, 32'h0003_0001, 8'h00, 8'h00};
    vecs[11] = '{1'b1, 32'h0003_0003, 8'h99, 8'h00};
    vecs[12] = '{1'b0, 32'h4001_FFFF, 8'h00, 8'h3C};

    step(); step();
    rst_in = 1'b0;
    chk("rst_mem_din", mem_din, 8'h00);
    chk("rst_ibf", io_buffer_full, 1'b0);
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_tx_ovf", tx_overflow, 1'b0);
    chk("rst_sim_done", sim_done, 1'b0);
    chk("rst_rx_ready", rx_ready, 1'b1);

    for (int i = 0; i < 13; i++) begin
      acc(vecs[i].wr, vecs[i].a, vecs[i].d);
      chk($sformatf("vec%0d_mem_din", i), mem_din, vecs[i].exp_din);
    end

    do_reset();
    acc(1'b0, 32'h10, 8'h00);
    chk("ram_kept_over_reset", mem_din, 8'hA5);

    // TX fill with sink stalled: 0x00 is skipped, ninth real byte dropped.
    wbytes = '{8'h41, 8'h00, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h49};
    tx_ready = 1'b0;
    accepted = 0;
    for (int i = 0; i < 10; i++) begin
      acc(1'b1, 32'h0003_0000, wbytes[i]);
      if (wbytes[i] != 8'h00 && accepted < 8) accepted++;
      chk($sformatf("tx_ibf_w%0d", i), io_buffer_full, (accepted >= 7) ? 1'b1 : 1'b0);
      chk($sformatf("tx_ovf_w%0d", i), tx_overflow, (wbytes[i] == 8'h49) ? 1'b1 : 1'b0);
    end
    tx_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("drain_valid%0d", k), tx_valid, 1'b1);
      chk($sformatf("drain_byte%0d", k), tx_byte, 8'h41 + 8'(k));
      step();
    end
    chk("drain_empty", tx_valid, 1'b0);
    chk("ovf_sticky", tx_overflow, 1'b1);
    tx_ready = 1'b0;

    // Counter snapshot taken at 255 so a live upper byte would read 0x01.
    do_reset();
    g = 0;
    while (exp_cnt != 32'd255 && g < 600) begin
      step();
      g++;
    end
    chk("cnt_reached", (g < 600) ? 1'b1 : 1'b0, 1'b1);
    cap = exp_cnt;
    acc(1'b0, 32'h0003_0004, 8'h00); b0 = mem_din;
    acc(1'b0, 32'h0003_0005, 8'h00); b1 = mem_din;
    acc(1'b0, 32'h0003_0006, 8'h00); b2 = mem_din;
    acc(1'b0, 32'h0003_0007, 8'h00); b3 = mem_din;
    chk("snap_b0", b0, cap[7:0]);
    chk("snap_b1", b1, cap[15:8]);
    chk("snap_word", {b3, b2, b1, b0}, cap);

    // RX FIFO
    rx_valid = 1'b1; rx_byte = 8'h31; step();
    rx_byte = 8'h32; step();
    rx_valid = 1'b0;
    acc(1'b0, 32'h0003_0000, 8'h00); chk("rx_pop0", mem_din, 8'h31);
    acc(1'b0, 32'h0003_0000, 8'h00); chk("rx_pop1", mem_din, 8'h32);
    acc(1'b0, 32'h0003_0000, 8'h00); chk("rx_pop_empty", mem_din, 8'h00);
    rx_valid = 1'b1;
    rx_byte = 8'h50; step();
    rx_byte = 8'h51; step();
    rx_byte = 8'h52; step();
    chk("rx_ready_cnt3", rx_ready, 1'b1);
    rx_byte = 8'h53;
    acc(1'b0, 32'h0003_0000, 8'h00);
    chk("rx_pushpop_din", mem_din, 8'h50);
    chk("rx_pushpop_ready", rx_ready, 1'b1);
    rx_byte = 8'h54; step();
    chk("rx_full_ready", rx_ready, 1'b0);
    rx_byte = 8'h55; step();
    rx_valid = 1'b0;
    chk("rx_full_hold", rx_ready, 1'b0);
    acc(1'b0, 32'h0003_0000, 8'h00); chk("rx_d0", mem_din, 8'h51);
    chk("rx_ready_after_pop", rx_ready, 1'b1);
    acc(1'b0, 32'h0003_0000, 8'h00); chk("rx_d1", mem_din, 8'h52);
    acc(1'b0, 32'h0003_0000, 8'h00); chk("rx_d2", mem_din, 8'h53);
    acc(1'b0, 32'h0003_0000, 8'h00); chk("rx_d3", mem_din, 8'h54);
    acc(1'b0, 32'h0003_0000, 8'h00); chk("rx_d4_empty", mem_din, 8'h00);

    // Stop request waits for the TX FIFO to drain
    tx_ready = 1'b0;
    acc(1'b1, 32'h0003_0000, 8'h61);
    acc(1'b1, 32'h0003_0000, 8'h62);
    acc(1'b1, 32'h0003_0000, 8'h63);
    acc(1'b1, 32'h0003_0004, 8'h00);
    chk("stop_pending0", sim_done, 1'b0);
    step();
    chk("stop_pending1", sim_done, 1'b0);
    tx_ready = 1'b1;
    g = 0;
    while (tx_valid && g < 10) begin
      step();
      g++;
    end
    chk("stop_drain_len", g, 3);
    chk("stop_at_empty", sim_done, 1'b0);
    step();
    chk("stop_done", sim_done, 1'b1);
    tx_ready = 1'b0;
    acc(1'b1, 32'h0003_0000, 8'h70);
    chk("stop_tx_refill", tx_valid, 1'b1);
    chk("stop_sticky", sim_done, 1'b1);

    // Mid-operation reset with both FIFOs occupied and a RAM write on the bus
    for (int i = 0; i < 6; i++) acc(1'b1, 32'h0003_0000, 8'h71 + 8'(i));
    chk("pre_rst_ibf", io_buffer_full, 1'b1);
    rx_valid = 1'b1; rx_byte = 8'h81; step();
    rx_valid = 1'b0;
    acc(1'b0, 32'h10, 8'h00);
    chk("pre_rst_din", mem_din, 8'hA5);
    rst_in = 1'b1; mem_wr = 1'b1; mem_a = 32'h10; mem_dout = 8'hEE;
    rx_valid = 1'b1; rx_byte = 8'h82;
    step();
    rx_valid = 1'b0;
    rst_in = 1'b0;
    chk("mid_rst_tx_valid", tx_valid, 1'b0);
    chk("mid_rst_rx_ready", rx_ready, 1'b1);
    chk("mid_rst_ibf", io_buffer_full, 1'b0);
    chk("mid_rst_din", mem_din, 8'h00);
    chk("mid_rst_sim_done", sim_done, 1'b0);
    acc(1'b0, 32'h0003_0000, 8'h00); chk("mid_rst_rx_empty", mem_din, 8'h00);
    acc(1'b0, 32'h10, 8'h00);        chk("mid_rst_ram", mem_din, 8'hA5);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
